// File: rtl/serial_compare_pkg.sv
// Shared types and constants for the serial MSB-first comparator controller.
package serial_compare_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    LT = 2'd0,
    GT = 2'd1,
    EQ = 2'd2
  } slice_res_e;

endpackage

// File: rtl/cmp_slice.sv
// Combinational 2-bit unsigned comparator; exactly one output is high.
module cmp_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       lt,
  output logic       gt,
  output logic       eq
);

  assign lt = (a < b);
  assign gt = (a > b);
  assign eq = (a == b);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Serial MSB-first unsigned compare, one 2-bit slice per RUN cycle.
// Macro SERIAL_COMPARE_EARLY_EXIT_EN ends the compare on the first unequal slice.
module serial_compare_ctrl
  import serial_compare_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int NSL   = WIDTH / 2,
  localparam int CW    = $clog2(NSL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic [CW-1:0]    slices_used,
  output logic [1:0]       state_dbg
);

  // Handshake: start is taken on any edge where busy=0 (IDLE or DONE);
  // the result is valid exactly in the cycle done=1 and holds afterwards.

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [CW-1:0]    cnt_q;
  logic             lt_q, gt_q, eq_q;
  logic [CW-1:0]    used_q;

  logic             s_lt, s_gt, s_eq;
  slice_res_e       slice_res, fin_res;
  logic             accept, last, finish;

  cmp_slice u_cmp (
    .a  (a_sh_q[WIDTH-1 -: 2]),
    .b  (b_sh_q[WIDTH-1 -: 2]),
    .lt (s_lt),
    .gt (s_gt),
    .eq (s_eq)
  );

  always_comb begin
    slice_res = EQ;
    if (s_lt)      slice_res = LT;
    else if (s_gt) slice_res = GT;
  end

  assign accept = (state_q != RUN) && start;
  assign last   = (cnt_q == CW'(NSL - 1));

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
  assign finish  = last || !s_eq;
  assign fin_res = slice_res;
`else
  // First unequal slice decides the result; later slices only run the clock out.
  slice_res_e res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= EQ;
    end else if (accept) begin
      res_q <= EQ;
    end else if (state_q == RUN && res_q == EQ) begin
      res_q <= slice_res;
    end
  end

  assign finish  = last;
  assign fin_res = (res_q == EQ) ? slice_res : res_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (finish) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      cnt_q  <= '0;
      lt_q   <= 1'b0;
      gt_q   <= 1'b0;
      eq_q   <= 1'b0;
      used_q <= '0;
    end else if (accept) begin
      a_sh_q <= a;
      b_sh_q <= b;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      a_sh_q <= {a_sh_q[WIDTH-3:0], 2'b00};
      b_sh_q <= {b_sh_q[WIDTH-3:0], 2'b00};
      cnt_q  <= cnt_q + CW'(1);
      if (finish) begin
        lt_q   <= (fin_res == LT);
        gt_q   <= (fin_res == GT);
        eq_q   <= (fin_res == EQ);
        used_q <= cnt_q + CW'(1);
      end
    end
  end

  assign lt          = lt_q;
  assign gt          = gt_q;
  assign eq          = eq_q;
  assign slices_used = used_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl (WIDTH=32) with an expected-result queue.
module tb_serial_compare_ctrl;
  import serial_compare_pkg::*;

  localparam int WIDTH = 32;
  localparam int NSL   = WIDTH / 2;
  localparam int CW    = $clog2(NSL + 1);
  localparam int W     = CW + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, done, lt, gt, eq;
  logic [CW-1:0]    slices_used;
  logic [1:0]       state_dbg;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  serial_compare_ctrl #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .lt          (lt),
    .gt          (gt),
    .eq          (eq),
    .slices_used (slices_used),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned relations; slice count from the highest differing slice.
  function automatic logic [W-1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [CW-1:0] used;
    used = CW'(NSL);
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    for (int i = 0; i < NSL; i++)
      if (x[2*i +: 2] != y[2*i +: 2]) used = CW'(NSL - i);
`endif
    return {x < y, x > y, x == y, used};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input bit toggle);
    logic [W-1:0] e;
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (toggle) begin
        start = 1'($urandom_range(0, 1));
        a     = $urandom;
      end
      step();
      n++;
    end
    check({tag, " done"}, done, 1'b1);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " qlen"}, (exp_q.size() > 0), 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, " latency"}, n, e[CW-1:0]);
      check({tag, " lt"}, lt, e[W-1]);
      check({tag, " gt"}, gt, e[W-2]);
      check({tag, " eq"}, eq, e[W-3]);
      check({tag, " used"}, slices_used, e[CW-1:0]);
    end
  endtask

  task automatic compare(input string tag, input logic [WIDTH-1:0] av,
                         input logic [WIDTH-1:0] bv, input bit toggle);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(model(av, bv));
    step();
    check({tag, " busy"}, busy, 1'b1);
    start = 1'b0;
    wait_done(tag, toggle);
    start = 1'b0;
    step();
    check({tag, " idle"}, state_dbg, IDLE);
    check({tag, " pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] r;
    #2;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst flags", {lt, gt, eq}, 3'b000);
    check("rst used", slices_used, '0);
    step();
    rst_n = 1'b1;
    step();

    compare("msb_gt", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);
    compare("equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    compare("lsb_lt", 32'h0000_0001, 32'h0000_0002, 1'b1);
    compare("zero", 32'h0, 32'h0, 1'b0);
    compare("max_lt", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      r = $urandom;
      compare("rnd_bit", r, r ^ (32'h1 << $urandom_range(0, WIDTH - 1)), 1'b0);
      compare("rnd", $urandom, $urandom, 1'b0);
    end

    // Back-to-back: start held through DONE.
    a = 32'd5;
    b = 32'd3;
    start = 1'b1;
    exp_q.push_back(model(32'd5, 32'd3));
    step();
    wait_done("b2b1", 1'b0);
    a = 32'd3;
    b = 32'd5;
    exp_q.push_back(model(32'd3, 32'd5));
    step();
    check("b2b state", state_dbg, RUN);
    check("b2b busy", busy, 1'b1);
    start = 1'b0;
    wait_done("b2b2", 1'b0);
    step();

    // Reset just before the 5th RUN edge of an equal compare; flags hold lt from above.
    a = 32'h0F0F_0F0F;
    b = 32'h0F0F_0F0F;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst busy", busy, 1'b0);
    check("mid_rst done", done, 1'b0);
    check("mid_rst flags", {lt, gt, eq}, 3'b000);
    check("mid_rst used", slices_used, '0);
    check("mid_rst state", state_dbg, IDLE);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst nodone", done, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_rst nodone", done, 1'b0);
    end
    compare("post_rst", 32'h1234_5678, 32'h1234_5679, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
